// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - RV32I load/store sequencer between the control unit and a word-addressed data memory
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (req_ready high only while idle)
//   req_we, req_func3        1=store/0=load, RV32I funct3 width/sign code
//   req_addr, req_wdata      effective byte address, store data (low bits significant)
//   rsp_valid                one-cycle completion pulse
//   rsp_rdata, rsp_err       extended load data (0 for stores/errors), error flag
//   mem_en, mem_we           memory access strobe and write
//   mem_addr, mem_be         word-aligned address, byte lane enables
//   mem_wdata                lane-replicated store data
//   mem_rdata, mem_ready     read word, access-complete strobe
module lsu_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_func3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t           state_q, state_d;
    logic [2:0]       func3_q, func3_d;
    logic [1:0]       off_q, off_d;
    logic             we_q, we_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic             mem_en_q, mem_en_d;
    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic             legal, misaligned;
    logic [3:0]       be_calc;
    logic [WIDTH-1:0] wdata_calc, lane, load_ext;

    // Request decode: func3[1:0] is the access size, func3[2] selects zero extension.
    always_comb begin
        legal      = (req_func3 == 3'b000) || (req_func3 == 3'b001) || (req_func3 == 3'b010) ||
                     (!req_we && ((req_func3 == 3'b100) || (req_func3 == 3'b101)));
        misaligned = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        case (req_func3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << req_addr[1:0];
                wdata_calc = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << req_addr[1:0];
                wdata_calc = {2{req_wdata[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = req_wdata;
            end
        endcase
    end

    // Load lane extraction: shift the addressed byte/half down to bit 0, then extend.
    always_comb begin
        lane = mem_rdata >> {off_q, 3'b000};
        case (func3_q)
            3'b000:  load_ext = {{(WIDTH-8){lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{(WIDTH-16){lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {{(WIDTH-8){1'b0}}, lane[7:0]};
            3'b101:  load_ext = {{(WIDTH-16){1'b0}}, lane[15:0]};
            default: load_ext = lane;
        endcase
        if (we_q) begin
            load_ext = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        func3_d     = func3_q;
        off_d       = off_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
                if (req_valid) begin
                    we_d    = req_we;
                    func3_d = req_func3;
                    off_d   = req_addr[1:0];
                    if (!legal || misaligned) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        cnt_d       = '0;
                        mem_en_d    = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[WIDTH-1:2], 2'b00};
                        mem_be_d    = be_calc;
                        mem_wdata_d = wdata_calc;
                    end
                end
            end
            ACCESS: begin
                if (mem_ready || (cnt_q == CW'(TIMEOUT - 1))) begin
                    // Ready on the final allowed cycle still counts as success.
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !mem_ready;
                    rsp_rdata_d = mem_ready ? load_ext : '0;
                    mem_en_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_be_d    = 4'b0000;
                    mem_wdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            func3_q     <= 3'b000;
            off_q       <= 2'b00;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            func3_q     <= func3_d;
            off_q       <= off_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl
module tb_lsu_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_en, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        int          waits;
        logic        mem;
        logic        err;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference built from the ISA rules: byte counts, lane offsets and integer extension.
    function automatic vec_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] mrd, input int waits);
        vec_t   v;
        int     n, off;
        longint val, span;
        bit     legal;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.mrd = mrd; v.waits = waits;
        n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off   = int'(addr % 4);
        legal = (f3 <= 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
        span  = longint'(1) << (8 * n);
        v.be = 4'd0;
        for (int i = 0; i < n; i++) v.be = v.be | 4'(1 << ((off + i) % 4));
        v.wd = 32'd0;
        for (int i = 0; i < 4 / n; i++) v.wd = v.wd | 32'((longint'(wdata) % span) << (8 * n * i));
        v.rd = 32'd0;
        if (!legal || (addr % n) != 0) begin
            v.mem = 1'b0;
            v.err = 1'b1;
        end else if (waits >= TO) begin
            v.mem = 1'b1;
            v.err = 1'b1;
        end else begin
            v.mem = 1'b1;
            v.err = 1'b0;
            if (!we) begin
                val = (longint'(mrd) >> (8 * off)) % span;
                if (!f3[2] && n < 4 && val >= span / 2) val = val - span;
                v.rd = 32'(val);
            end
        end
        return v;
    endfunction

    task automatic do_op(input vec_t v, input string tag);
        int cyc, en_cnt, bad, exp_lat, exp_en;
        bit done;
        check({tag, " req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = v.we; req_func3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata;
        mem_ready = 1'($urandom); mem_rdata = $urandom;
        @(posedge clk);
        @(negedge clk);
        cyc = 1; en_cnt = 0; bad = 0; done = 0;
        while (!done && cyc < 40) begin
            if (rsp_valid) begin
                done = 1;
            end else begin
                req_valid = 1'($urandom); req_we = 1'($urandom); req_func3 = 3'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
                if (mem_en) begin
                    en_cnt++;
                    if (mem_we !== v.we || mem_addr !== (v.addr & 32'hFFFF_FFFC) ||
                        mem_be !== v.be || (v.we && mem_wdata !== v.wd)) bad++;
                    mem_ready = (en_cnt > v.waits);
                    mem_rdata = mem_ready ? v.mrd : $urandom;
                end else begin
                    mem_ready = 1'($urandom);
                    mem_rdata = $urandom;
                end
                @(negedge clk);
                cyc++;
            end
        end
        req_valid = 1'b0;
        mem_ready = 1'b0;
        exp_lat = !v.mem ? 1 : (v.err ? TO + 1 : v.waits + 2);
        exp_en  = !v.mem ? 0 : (v.err ? TO : v.waits + 1);
        check({tag, " rsp_seen"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " mem_en_cycles"}, 32'(en_cnt), 32'(exp_en));
        check({tag, " mem_bus_fields"}, 32'(bad), 32'd0);
        check({tag, " rsp_err"}, 32'(rsp_err), 32'(v.err));
        check({tag, " rsp_rdata"}, rsp_rdata, v.rd);
        check({tag, " mem_en_off_in_resp"}, 32'(mem_en), 32'd0);
        @(negedge clk);
        check({tag, " rsp_valid_one_cycle"}, 32'(rsp_valid), 32'd0);
        check({tag, " rsp_err_cleared"}, 32'(rsp_err), 32'd0);
        check({tag, " back_to_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int   seen;
        vec_t v;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;

        //            we f3      addr          wdata          mem_rdata     w  mem err be       wd             rd
        tbl[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 1'b1, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        0, 1'b1, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0};
        tbl[2]  = '{1'b0, 3'b000, 32'h101, 32'h0,        32'h123480FF, 0, 1'b1, 1'b0, 4'b0010, 32'h0,        32'hFFFFFF80};
        tbl[3]  = '{1'b0, 3'b100, 32'h101, 32'h0,        32'h123480FF, 0, 1'b1, 1'b0, 4'b0010, 32'h0,        32'h00000080};
        tbl[4]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h80010000, 3, 1'b1, 1'b0, 4'b1100, 32'h0,        32'hFFFF8001};
        tbl[5]  = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h80010000, 3, 1'b1, 1'b0, 4'b1100, 32'h0,        32'h00008001};
        tbl[6]  = '{1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[7]  = '{1'b1, 3'b001, 32'h101, 32'h1234,     32'h0,        0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[8]  = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[9]  = '{1'b0, 3'b010, 32'h200, 32'h0,        32'h55AA55AA, 9, 1'b1, 1'b1, 4'b1111, 32'h0,        32'h0};
        tbl[10] = '{1'b1, 3'b100, 32'h100, 32'h0,        32'h0,        0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[11] = '{1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,        1, 1'b1, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset mem_en", 32'(mem_en), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset mem_be", 32'(mem_be), 32'd0);
        check("reset mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) do_op(tbl[i], $sformatf("vec%0d", i));

        // Abort in the middle of an access.
        req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h40;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort mem_en_before", 32'(mem_en), 32'd1);
        rst = 1'b1; mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort mem_en", 32'(mem_en), 32'd0);
        check("abort mem_be", 32'(mem_be), 32'd0);
        check("abort mem_addr", mem_addr, 32'd0);
        check("abort req_ready", 32'(req_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        check("abort no_rsp", 32'(seen), 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = {24'h0, 8'($urandom)};
            v = model(1'($urandom), 3'($urandom), a, $urandom, $urandom, $urandom_range(0, 5));
            do_op(v, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
